tow_scorer: RTL and testbench

- Datapath/responder end of the Tug-of-War round-control interface.
- Consumes the controller's leds_on, led_ctrl and clr, tracks rope position from the two player pushbuttons, and drives the LED bar.
- Detects round wins and false starts and returns winrnd to the controller.
- Keeps per-player saturating round scores for the display logic.

---
 rtl/tow_scorer.sv | 169 ++++++++++++++++
 tb/tb_tow_scorer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tow_scorer.sv
// -----------------------------------------------------------------------------
// tow_scorer
// Datapath/responder side of the Tug-of-War round controller. Tracks the rope
// position from the two player buttons, drives the LED bar, flags round wins
// and false starts back to the controller, and keeps saturating per-player
// round scores.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   pb_l      left player button (debounced, synchronous level)
//   pb_r      right player button (debounced, synchronous level)
//   leds_on   0 blanks the LED bar
//   led_ctrl  11 all on, 00 dark/armed, 10 (or 01) show rope position
//   clr       1 disables scoring and clears winrnd; 1->0 recentres the rope
//   winrnd    registered round-won flag back to the controller
//   winner    registered winner of the last round (0 left, 1 right)
//   leds      LED bar
//   score_l   left rounds won (saturating)
//   score_r   right rounds won (saturating)
// -----------------------------------------------------------------------------
module tow_scorer #(
  parameter  int N_LEDS  = 9,
  parameter  int SCORE_W = 4,
  localparam int POS_W   = $clog2(N_LEDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pb_l,
  input  logic               pb_r,
  input  logic               leds_on,
  input  logic [1:0]         led_ctrl,
  input  logic               clr,
  output logic               winrnd,
  output logic               winner,
  output logic [N_LEDS-1:0]  leds,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r
);

  localparam logic [POS_W-1:0]   CTR       = POS_W'((N_LEDS - 1) / 2);
  localparam logic [POS_W-1:0]   LAST      = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0]   NEAR_LAST = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0]   ONE       = POS_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  // Registered state
  logic [POS_W-1:0]   pos_q,     pos_d;
  logic               winrnd_q,  winrnd_d;
  logic               winner_q,  winner_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               prev_l_q,  prev_r_q, prev_clr_q;

  // Decoded conditions
  logic press_l;
  logic press_r;
  logic recentre;
  logic active;
  logic one_press;
  logic mode_dark;
  logic mode_play;

  // Rising-edge presses; the previous-level registers run in every mode so a
  // button held through a clr release does not count as a fresh press.
  assign press_l   = pb_l & ~prev_l_q;
  assign press_r   = pb_r & ~prev_r_q;
  assign recentre  = prev_clr_q & ~clr;
  assign active    = ~clr & ~winrnd_q;
  // Both buttons rising in the same cycle cancel each other out.
  assign one_press = press_l ^ press_r;
  assign mode_dark = (led_ctrl == 2'b00);
  // 01 is reserved and behaves like 10.
  assign mode_play = led_ctrl[1] ^ led_ctrl[0];

  always_comb begin
    pos_d     = pos_q;
    winrnd_d  = winrnd_q;
    winner_d  = winner_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;

    // winrnd stays up until clr is seen, then drops on the following edge.
    if (clr) begin
      winrnd_d = 1'b0;
    end

    if (recentre) begin
      // Presses in the recentre cycle are deliberately discarded.
      pos_d = CTR;
    end else if (active && one_press) begin
      if (mode_dark) begin
        // False start: the opponent of whoever pressed takes the round and
        // the rope is parked at the winner's end for the gloat display.
        winrnd_d = 1'b1;
        if (press_l) begin
          winner_d = 1'b1;
          pos_d    = LAST;
          if (score_r_q != SCORE_MAX) score_r_d = score_r_q + 1'b1;
        end else begin
          winner_d = 1'b0;
          pos_d    = '0;
          if (score_l_q != SCORE_MAX) score_l_d = score_l_q + 1'b1;
        end
      end else if (mode_play) begin
        if (press_l) begin
          // <= keeps pos in range even if an end were ever reached while active.
          if (pos_q <= ONE) begin
            pos_d    = '0;
            winrnd_d = 1'b1;
            winner_d = 1'b0;
            if (score_l_q != SCORE_MAX) score_l_d = score_l_q + 1'b1;
          end else begin
            pos_d = pos_q - ONE;
          end
        end else begin
          if (pos_q >= NEAR_LAST) begin
            pos_d    = LAST;
            winrnd_d = 1'b1;
            winner_d = 1'b1;
            if (score_r_q != SCORE_MAX) score_r_d = score_r_q + 1'b1;
          end else begin
            pos_d = pos_q + ONE;
          end
        end
      end
      // led_ctrl = 11: presses ignored.
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q      <= CTR;
      winrnd_q   <= 1'b0;
      winner_q   <= 1'b0;
      score_l_q  <= '0;
      score_r_q  <= '0;
      prev_l_q   <= 1'b0;
      prev_r_q   <= 1'b0;
      prev_clr_q <= 1'b1;
    end else begin
      pos_q      <= pos_d;
      winrnd_q   <= winrnd_d;
      winner_q   <= winner_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      prev_l_q   <= pb_l;
      prev_r_q   <= pb_r;
      prev_clr_q <= clr;
    end
  end

  // LED bar: blanked by leds_on, otherwise all-on, dark, or one-hot at pos.
  logic all_on;
  assign all_on = (led_ctrl == 2'b11);

  genvar gi;
  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_led
      assign leds[gi] = leds_on & (all_on | (mode_play & (pos_q == POS_W'(gi))));
    end
  endgenerate

  assign winrnd  = winrnd_q;
  assign winner  = winner_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_tow_scorer.sv
// -----------------------------------------------------------------------------
// tb_tow_scorer
// Directed scenarios followed by a randomized run, all compared against a
// behavioural model of the rope game kept in plain integers.
// -----------------------------------------------------------------------------
module tb_tow_scorer;

  localparam int N    = 9;
  localparam int SW   = 4;
  localparam int CTR  = 4;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          pb_l, pb_r, leds_on, clr;
  logic [1:0]    led_ctrl;
  logic          winrnd, winner;
  logic [N-1:0]  leds;
  logic [SW-1:0] score_l, score_r;

  tow_scorer #(.N_LEDS(N), .SCORE_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pb_l     (pb_l),
    .pb_r     (pb_r),
    .leds_on  (leds_on),
    .led_ctrl (led_ctrl),
    .clr      (clr),
    .winrnd   (winrnd),
    .winner   (winner),
    .leds     (leds),
    .score_l  (score_l),
    .score_r  (score_r)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_pos, m_win, m_winner, m_sl, m_sr, m_pl, m_pr, m_pclr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pos = CTR; m_win = 0; m_winner = 0; m_sl = 0; m_sr = 0;
    m_pl = 0; m_pr = 0; m_pclr = 1;
  endtask

  function automatic int sat_inc(int v);
    return (v < SMAX) ? v + 1 : SMAX;
  endfunction

  // One clock edge of the game, from the rules: move the rope one step
  // toward the presser; reaching either end wins for that side.
  task automatic model_edge();
    int  pos_n, win_n, winner_n, sl_n, sr_n;
    bit  pl, pr;
    pos_n = m_pos; win_n = m_win; winner_n = m_winner; sl_n = m_sl; sr_n = m_sr;
    pl = (pb_l === 1'b1) && (m_pl == 0);
    pr = (pb_r === 1'b1) && (m_pr == 0);
    if (clr) win_n = 0;
    if (m_pclr == 1 && !clr) begin
      pos_n = CTR;
    end else if (!clr && m_win == 0 && pl != pr) begin
      if (led_ctrl == 2'b00) begin
        win_n = 1;
        if (pl) begin winner_n = 1; sr_n = sat_inc(m_sr); pos_n = N - 1; end
        else    begin winner_n = 0; sl_n = sat_inc(m_sl); pos_n = 0;     end
      end else if (led_ctrl != 2'b11) begin
        pos_n = pl ? m_pos - 1 : m_pos + 1;
        if (pos_n == 0)          begin win_n = 1; winner_n = 0; sl_n = sat_inc(m_sl); end
        else if (pos_n == N - 1) begin win_n = 1; winner_n = 1; sr_n = sat_inc(m_sr); end
      end
    end
    m_pos = pos_n; m_win = win_n; m_winner = winner_n; m_sl = sl_n; m_sr = sr_n;
    m_pl = int'(pb_l); m_pr = int'(pb_r); m_pclr = int'(clr);
  endtask

  function automatic logic [N-1:0] exp_leds();
    logic [N-1:0] one;
    one = 1;
    if (!leds_on) return '0;
    case (led_ctrl)
      2'b11:   return '1;
      2'b00:   return '0;
      default: return one << m_pos;
    endcase
  endfunction

  task automatic check_outputs(string tag);
    chk({tag, ".winrnd"},  32'(winrnd),  32'(m_win));
    chk({tag, ".winner"},  32'(winner),  32'(m_winner));
    chk({tag, ".leds"},    32'(leds),    32'(exp_leds()));
    chk({tag, ".score_l"}, 32'(score_l), 32'(m_sl));
    chk({tag, ".score_r"}, 32'(score_r), 32'(m_sr));
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic pulse_l(string tag);
    pb_l = 1'b1; step(tag);
    pb_l = 1'b0; step({tag, "_rel"});
  endtask

  task automatic pulse_r(string tag);
    pb_r = 1'b1; step(tag);
    pb_r = 1'b0; step({tag, "_rel"});
  endtask

  task automatic new_round();
    clr = 1'b1; step("clr_hi");
    clr = 1'b0; step("clr_lo");
  endtask

  logic [N-1:0] exp_seq [4];

  initial begin
    exp_seq = '{9'h008, 9'h004, 9'h002, 9'h001};
    rst = 1'b1; pb_l = 1'b0; pb_r = 1'b0;
    leds_on = 1'b1; led_ctrl = 2'b11; clr = 1'b1;
    model_reset();

    // Reset for 3 clocks, release away from the edge
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("reset");
    chk("reset.leds_all", 32'(leds), 32'h1FF);

    // Play: four left presses walk the rope to the left end
    clr = 1'b0; led_ctrl = 2'b10;
    step("recentre");
    chk("recentre.leds", 32'(leds), 32'h010);
    for (int i = 0; i < 4; i++) begin
      pulse_l("walk_l");
      chk($sformatf("walk_l%0d.leds", i), 32'(leds), 32'(exp_seq[i]));
    end
    chk("win_l.winrnd",  32'(winrnd),  32'd1);
    chk("win_l.winner",  32'(winner),  32'd0);
    chk("win_l.score_l", 32'(score_l), 32'd1);
    pulse_l("fifth");
    chk("fifth.leds", 32'(leds), 32'h001);

    // Dark mode false start by the right player
    clr = 1'b1; step("fs_clr");
    clr = 1'b0; led_ctrl = 2'b00; step("fs_arm");
    pb_r = 1'b1; step("fs_press");
    chk("fs.leds_dark", 32'(leds),    32'h000);
    chk("fs.winrnd",    32'(winrnd),  32'd1);
    chk("fs.winner",    32'(winner),  32'd0);
    chk("fs.score_l",   32'(score_l), 32'd2);
    pb_r = 1'b0; step("fs_rel");
    led_ctrl = 2'b10;
    #1;
    chk("fs.leds_show", 32'(leds), 32'h001);

    // Simultaneous presses cancel
    new_round();
    pb_l = 1'b1; pb_r = 1'b1; step("simul");
    chk("simul.leds",   32'(leds),   32'h010);
    chk("simul.winrnd", 32'(winrnd), 32'd0);
    pb_l = 1'b0; pb_r = 1'b0; step("simul_rel");

    // Button held across the clr release is not a press
    clr = 1'b1; step("hold_clr");
    pb_r = 1'b1; step("hold_press");
    clr = 1'b0; step("hold_release");
    step("hold_still");
    chk("hold.leds", 32'(leds), 32'h010);
    pb_r = 1'b0; step("hold_up");
    pulse_r("hold_fresh");
    chk("hold_fresh.leds", 32'(leds), 32'h020);

    // Left score saturates
    for (int w = 0; w < 16; w++) begin
      new_round();
      repeat (4) pulse_l("sat");
    end
    chk("sat.score_l", 32'(score_l), 32'd15);

    // Asynchronous reset while winrnd is high
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_win.winrnd", 32'(winrnd), 32'd0);
    chk("arst_win.score_l", 32'(score_l), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pclr = 1; m_pl = 0; m_pr = 0;

    // Asynchronous reset mid-play at pos 2
    led_ctrl = 2'b10; clr = 1'b0;
    step("rst2_recentre");
    pulse_l("rst2_a");
    pulse_l("rst2_b");
    chk("rst2.pre_leds", 32'(leds), 32'h004);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("rst2.leds",   32'(leds),   32'h010);
    chk("rst2.winrnd", 32'(winrnd), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized play against the model
    for (int c = 0; c < 600; c++) begin
      pb_l = ($urandom_range(0, 2) == 0);
      pb_r = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) led_ctrl = 2'($urandom_range(0, 3));
      leds_on = ($urandom_range(0, 7) != 0);
      if (m_win == 1) clr = ($urandom_range(0, 2) == 0);
      else            clr = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
